aib_io_cfg_ctrl: RTL and testbench

Configuration controller for the AIB IO buffer array. It takes single-IO or broadcast configuration writes over a valid/ready request port and holds the per-IO configuration registers that drive the buffer array's `c_*` inputs. When a write flips an IO's direction, the controller first parks the affected IOs in a safe non-driving state for a guard interval, so two dies never drive a pad at the same time.

---
 rtl/aib_io_cfg_ctrl.sv | 130 +++++++++++++
 tb/tb_aib_io_cfg_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/aib_io_cfg_ctrl.sv
// aib_io_cfg_ctrl: per-IO configuration register bank for the AIB IO buffer
// array. It accepts single-IO or broadcast writes. A write that flips an
// IO's direction first parks the targets in a safe non-driving state for a
// guard interval, then applies the new configuration.
module aib_io_cfg_ctrl #(
  parameter int unsigned NumIo       = 96,
  parameter int unsigned GuardCycles = 4,
  parameter int unsigned IdxW        = $clog2(NumIo)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_bcast,
  input  logic [IdxW-1:0] i_req_idx,
  input  logic [8:0]      i_req_cfg,
  output logic            o_err,
  output logic            o_busy,
  output logic            c_io_tx_en      [NumIo-1:0],
  output logic            c_io_ddr_mode   [NumIo-1:0],
  output logic            c_io_async_mode [NumIo-1:0],
  output logic            c_drv_pull_up   [NumIo-1:0],
  output logic            c_drv_pull_down [NumIo-1:0],
  output logic [3:0]      c_drv_strength  [NumIo-1:0]
);

  localparam int unsigned CntW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

  typedef enum logic [1:0] {IDLE, QUIESCE, GUARD, APPLY} state_t;

  state_t            state;
  logic [CntW-1:0]   cnt;
  logic              hold_bcast;
  logic [IdxW-1:0]   hold_idx;
  logic [8:0]        hold_cfg;
  logic              dir_change;
  logic              idx_bad;

  // True when IO i belongs to the latched request's target set.
  function automatic logic is_tgt(input int unsigned i);
    return hold_bcast || (hold_idx == IdxW'(i));
  endfunction

  // Decode the incoming request: out-of-range index and direction flip.
  always_comb begin
    dir_change = 1'b0;
    idx_bad    = !i_req_bcast && (32'(i_req_idx) >= NumIo);
    for (int unsigned i = 0; i < NumIo; i++) begin
      if ((i_req_bcast || (i_req_idx == IdxW'(i))) &&
          (c_io_tx_en[i] != i_req_cfg[8]))
        dir_change = 1'b1;
    end
  end

  // Sequencer plus configuration registers, all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      hold_bcast  <= 1'b0;
      hold_idx    <= '0;
      hold_cfg    <= '0;
      for (int unsigned i = 0; i < NumIo; i++) begin
        c_io_tx_en[i]      <= 1'b0;
        c_io_ddr_mode[i]   <= 1'b0;
        c_io_async_mode[i] <= 1'b0;
        c_drv_pull_up[i]   <= 1'b0;
        c_drv_pull_down[i] <= 1'b1;
        c_drv_strength[i]  <= '0;
      end
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            if (idx_bad) begin
              o_err <= 1'b1;
            end else begin
              hold_bcast  <= i_req_bcast;
              hold_idx    <= i_req_idx;
              hold_cfg    <= i_req_cfg;
              state       <= dir_change ? QUIESCE : APPLY;
              o_req_ready <= 1'b0;
              o_busy      <= 1'b1;
            end
          end
        end
        QUIESCE: begin
          for (int unsigned i = 0; i < NumIo; i++) begin
            if (is_tgt(i)) begin
              c_io_tx_en[i]      <= 1'b0;
              c_drv_pull_up[i]   <= 1'b0;
              c_drv_pull_down[i] <= 1'b1;
            end
          end
          cnt   <= CntW'(GuardCycles - 1);
          state <= GUARD;
        end
        GUARD: begin
          if (cnt == '0) state <= APPLY;
          else           cnt   <= cnt - 1'b1;
        end
        APPLY: begin
          for (int unsigned i = 0; i < NumIo; i++) begin
            if (is_tgt(i)) begin
              c_io_tx_en[i]      <= hold_cfg[8];
              c_io_ddr_mode[i]   <= hold_cfg[7];
              c_io_async_mode[i] <= hold_cfg[6];
              c_drv_strength[i]  <= hold_cfg[5:2];
              c_drv_pull_up[i]   <= hold_cfg[1];
              c_drv_pull_down[i] <= hold_cfg[0];
            end
          end
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aib_io_cfg_ctrl.sv
// tb_aib_io_cfg_ctrl: directed and randomized writes checked against an
// array model of the IO configuration and the expected handshake timing.
module tb_aib_io_cfg_ctrl;

  localparam int N = 96;
  localparam int G = 4;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         ready;
  logic         bcast;
  logic [W-1:0] req_idx;
  logic [8:0]   req_cfg;
  logic         err;
  logic         busy;
  logic         tx  [N-1:0];
  logic         ddr [N-1:0];
  logic         asy [N-1:0];
  logic         pu  [N-1:0];
  logic         pd  [N-1:0];
  logic [3:0]   st  [N-1:0];

  // Model of the configuration registers.
  logic         m_tx  [N];
  logic         m_ddr [N];
  logic         m_asy [N];
  logic         m_pu  [N];
  logic         m_pd  [N];
  logic [3:0]   m_st  [N];

  int vec = 0;
  int mis = 0;

  aib_io_cfg_ctrl #(.NumIo(N), .GuardCycles(G)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_bcast(bcast), .i_req_idx(req_idx), .i_req_cfg(req_cfg),
    .o_err(err), .o_busy(busy),
    .c_io_tx_en(tx), .c_io_ddr_mode(ddr), .c_io_async_mode(asy),
    .c_drv_pull_up(pu), .c_drv_pull_down(pd), .c_drv_strength(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cfg(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < N; i++) begin
      if (tx[i] !== m_tx[i] || ddr[i] !== m_ddr[i] || asy[i] !== m_asy[i] ||
          pu[i] !== m_pu[i] || pd[i] !== m_pd[i] || st[i] !== m_st[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("  %s: first differing IO %0d", tag, first);
    chk(tag, bad, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tx[i] = 0; m_ddr[i] = 0; m_asy[i] = 0; m_pu[i] = 0; m_pd[i] = 1; m_st[i] = 4'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction with timing checks; the model is updated at the
  // points where the block's outputs are required to change.
  task automatic write(input bit b, input int idx, input logic [8:0] cfg);
    int  n = 0;
    bit  dc = 0;
    bit  bad;
    while (!ready && n < 50) begin step(); n++; end
    chk("ready_before_req", ready, 1);
    valid = 1; bcast = b; req_idx = W'(idx); req_cfg = cfg;
    step();
    valid = 0; bcast = $urandom; req_idx = W'($urandom); req_cfg = 9'($urandom);
    bad = !b && idx >= N;
    if (bad) begin
      chk("err_pulse", err, 1);
      chk("ready_on_bad", ready, 1);
      chk_cfg("cfg_unchanged_bad");
      step();
      chk("err_clear", err, 0);
      return;
    end
    for (int i = 0; i < N; i++)
      if ((b || i == idx) && m_tx[i] != cfg[8]) dc = 1;
    chk("err_quiet", err, 0);
    chk("ready_low", ready, 0);
    chk("busy_high", busy, 1);
    step();
    if (dc) begin
      for (int i = 0; i < N; i++)
        if (b || i == idx) begin m_tx[i] = 0; m_pu[i] = 0; m_pd[i] = 1; end
      chk_cfg("cfg_safe");
      chk("busy_guard", busy, 1);
      for (int k = 0; k < G; k++) begin
        step();
        chk("busy_guard", busy, 1);
      end
      chk_cfg("cfg_still_safe");
      step();
    end
    for (int i = 0; i < N; i++)
      if (b || i == idx) begin
        m_tx[i] = cfg[8]; m_ddr[i] = cfg[7]; m_asy[i] = cfg[6];
        m_st[i] = cfg[5:2]; m_pu[i] = cfg[1]; m_pd[i] = cfg[0];
      end
    chk_cfg("cfg_final");
    chk("ready_after", ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    valid = 0; bcast = 0; req_idx = '0; req_cfg = '0;
    rst = 1;
    model_reset();
    #2;
    // Reset takes effect before any clock edge.
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk_cfg("rst_cfg");
    step(); step();
    rst = 0;
    step();

    // Single IO, no direction change.
    write(0, 5, 9'h0AA);
    // Direction change on IO7.
    write(0, 7, 9'h1C5);
    // Bring IO7 back to rx, set IO3 to tx, then broadcast tx.
    write(0, 7, 9'h001);
    write(0, 3, 9'h13D);
    write(1, 0, 9'h1F2);
    // Broadcast that matches every direction: no quiesce path.
    write(1, 0, 9'h14C);
    // Out-of-range index.
    write(0, 100, 9'h1FF);
    write(0, 127, 9'h000);
    // Boundary indices.
    write(0, 0, 9'h0FF);
    write(0, 95, 9'h101);

    // Reset while in GUARD after a direction change.
    valid = 1; bcast = 0; req_idx = W'(20); req_cfg = 9'h0D3 ^ {~m_tx[20], 8'h00};
    step();
    valid = 0;
    step(); step(); step();
    #1 rst = 1;
    #1;
    model_reset();
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk_cfg("midrst_cfg");
    #1 rst = 0;
    step();
    write(0, 20, 9'h1A6);

    // Randomized writes.
    for (int t = 0; t < 40; t++) begin
      bit          b   = ($urandom_range(0, 7) == 0);
      int          idx = $urandom_range(0, 127);
      logic [8:0]  cfg = 9'($urandom);
      // Hold valid high while busy before the next accept in some iterations.
      if ($urandom_range(0, 1) == 1) valid = 1;
      write(b, idx, cfg);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
